// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst master: access-size encodings,
// controller states, beat-count helper and the default lowest legal address.
package mem_pkg;

  localparam logic [1:0] sz_word  = 2'b00;
  localparam logic [1:0] sz_4word = 2'b01;
  localparam logic [1:0] sz_8word = 2'b10;
  localparam logic [1:0] sz_byte  = 2'b11;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8002_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // Number of memory cycles a request of the given size occupies.
  function automatic logic [3:0] beats_of(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      sz_4word: n = 4'd4;
      sz_8word: n = 4'd8;
      sz_word:  n = 4'd1;
      sz_byte:  n = 4'd1;
      default:  n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Loadable 4-bit down-counter with a zero flag; counts the ACCESS cycles
// of one request.
module mem_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_burst_master.sv
// Initiator-side controller for the instruction/data memory port.
// Accepts one byte/word/4-word/8-word request at a time, drives the memory
// for N cycles, returns read beats one cycle later and pops write beats.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, misaligned word and
// burst requests are rejected; otherwise their low address bits are cleared.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rd_wr,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_busy
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic              rd_valid_q;
  logic              ready_s;
  logic              accept_s;
  logic              illegal_s;
  logic              misalign_s;
  logic [ADDR_W-1:0] addr_in_s;
  logic [3:0]        cnt_s;
  logic              cnt_zero_s;

  assign ready_s  = (state_q == IDLE) & ~mem_busy & ~rst;
  assign accept_s = ready_s & req_valid;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (req_size != sz_byte) && (req_addr[1:0] != 2'b00);
  assign addr_in_s  = req_addr;
`else
  assign misalign_s = 1'b0;
  assign addr_in_s  = (req_size == sz_byte) ? req_addr
                                            : {req_addr[ADDR_W-1:2], 2'b00};
`endif

  assign illegal_s = (req_addr < BASE_ADDR) | misalign_s;

  mem_beat_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .load_val (beats_of(req_size)),
    .dec      (state_q == ACCESS),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request attributes at acceptance; held for the whole request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= 2'b00;
      wr_q   <= 1'b0;
    end else if (accept_s) begin
      addr_q <= addr_in_s;
      size_q <= req_size;
      wr_q   <= req_wr;
    end
  end

  // Read pipe: memory answers one cycle after each read ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == ACCESS) & ~wr_q;
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d         = state_q;
    mem_enable      = 1'b0;
    mem_addr        = '0;
    mem_access_size = 2'b00;
    mem_rd_wr       = 1'b0;
    mem_data_in     = '0;
    wr_pop          = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = illegal_s ? ERR : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_enable      = 1'b1;
        mem_addr        = addr_q;
        mem_access_size = size_q;
        mem_rd_wr       = ~wr_q;
        if (wr_q) begin
          wr_pop      = 1'b1;
          mem_data_in = (size_q == sz_byte) ? {{(DATA_W-8){1'b0}}, wr_data[7:0]}
                                            : wr_data;
        end else begin
          wr_pop      = 1'b0;
        end
        if (cnt_s == 4'd1) begin
          state_d = wr_q ? DONE : WAIT;
        end else begin
          state_d = ACCESS;
        end
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = ready_s;
  assign rd_valid  = rd_valid_q;
  // The counter has reached zero exactly when the final beat is presented.
  assign rd_last   = rd_valid_q & cnt_zero_s;
  // Byte reads mask the memory's undriven upper lanes.
  assign rd_data   = !rd_valid_q ? '0 :
                     (size_q == sz_byte) ? {{(DATA_W-8){1'b0}}, mem_data_out[7:0]}
                                         : mem_data_out;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed self-checking bench for mem_burst_master with a small big-endian
// burst memory model (read latency 1, upper lanes junk on byte reads).
module tb_mem_burst_master;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_wr = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, done, err;
  logic [31:0] mem_addr, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr, mem_enable;
  logic [31:0] mem_data_out = 32'd0;
  logic        mem_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_burst_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_wr(req_wr),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
    .mem_enable(mem_enable), .mem_data_out(mem_data_out), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic        mem_en_prev = 1'b0;
  logic [31:0] burst_addr  = 32'd0;
  logic [31:0] eff_addr;
  logic [5:0]  eidx;
  int          lane;
  assign eff_addr = mem_en_prev ? burst_addr + 32'd4 : mem_addr;
  assign eidx     = eff_addr[7:2];
  assign lane     = 8 * (3 - int'(eff_addr[1:0]));

  always @(posedge clk) begin
    mem_en_prev <= mem_enable;
    if (mem_enable) begin
      burst_addr <= eff_addr;
      if (mem_rd_wr) begin
        if (mem_access_size == sz_byte)
          mem_data_out <= {24'hFFFFFF, mem[eidx][lane +: 8]};
        else
          mem_data_out <= mem[eidx];
      end else begin
        if (mem_access_size == sz_byte)
          mem[eidx][lane +: 8] <= mem_data_in[7:0];
        else
          mem[eidx] <= mem_data_in;
      end
    end
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h11223344;
    if (i == 1) return 32'hDEADBEEF;
    return 32'hC0DE0000 + 32'(i);
  endfunction

  // ---------------- trace capture ----------------
  logic [31:0] wvals [0:7];
  logic        tr_ready0;
  logic        tr_en [16], tr_rw [16], tr_pop [16], tr_rv [16], tr_rl [16];
  logic        tr_done [16], tr_err [16];
  logic [31:0] tr_addr [16], tr_din [16], tr_rd [16];

  task automatic do_req(input logic [31:0] a, input logic [1:0] s, input logic w);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_size = s; req_wr = w; wr_data = 32'd0;
    #1;
    tr_ready0 = req_ready;
    for (int c = 1; c < 16; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (c <= 8) wr_data = wvals[c-1];
      else        wr_data = 32'd0;
      #1;
      tr_en[c] = mem_enable;  tr_addr[c] = mem_addr; tr_din[c] = mem_data_in;
      tr_rw[c] = mem_rd_wr;   tr_pop[c]  = wr_pop;   tr_rv[c]  = rd_valid;
      tr_rl[c] = rd_last;     tr_rd[c]   = rd_data;  tr_done[c] = done;
      tr_err[c] = err;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    n_checks++; if ({mem_enable, mem_rd_wr, rd_valid, done, err, wr_pop} !== 6'b0) begin n_fail++; $display("FAIL reset_ctl got %b exp 000000", {mem_enable, mem_rd_wr, rd_valid, done, err, wr_pop}); end
    n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    @(posedge clk); #1; rst = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_read_word();
    do_req(32'h80020004, sz_word, 1'b0);
    n_checks++; if (tr_ready0 !== 1'b1) begin n_fail++; $display("FAIL rw_ready got %b exp 1", tr_ready0); end
    n_checks++; if (tr_addr[1] !== 32'h80020004 || tr_rw[1] !== 1'b1) begin n_fail++; $display("FAIL rw_memaddr got %h/%b exp 80020004/1", tr_addr[1], tr_rw[1]); end
    n_checks++; if (tr_rd[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_data got %h exp deadbeef", tr_rd[2]); end
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if ({tr_en[c], tr_rv[c], tr_rl[c], tr_done[c], tr_err[c], tr_pop[c]} !==
          {c == 1, c == 2, c == 2, c == 3, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL rw_ctl cycle %0d got %b exp %b", c,
          {tr_en[c], tr_rv[c], tr_rl[c], tr_done[c], tr_err[c], tr_pop[c]},
          {c == 1, c == 2, c == 2, c == 3, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_read_8word();
    do_req(32'h80020000, sz_8word, 1'b0);
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if ({tr_en[c], tr_rv[c], tr_rl[c], tr_done[c], tr_pop[c]} !==
          {(c >= 1 && c <= 8), (c >= 2 && c <= 9), c == 9, c == 10, 1'b0}) begin
        n_fail++; $display("FAIL r8_ctl cycle %0d got %b exp %b", c,
          {tr_en[c], tr_rv[c], tr_rl[c], tr_done[c], tr_pop[c]},
          {(c >= 1 && c <= 8), (c >= 2 && c <= 9), c == 9, c == 10, 1'b0});
      end
      if (c >= 1 && c <= 8) begin
        n_checks++; if (tr_addr[c] !== 32'h80020000) begin n_fail++; $display("FAIL r8_addr_held cycle %0d got %h exp 80020000", c, tr_addr[c]); end
      end
      if (c >= 2 && c <= 9) begin
        n_checks++; if (tr_rd[c] !== init_word(c - 2)) begin n_fail++; $display("FAIL r8_data beat %0d got %h exp %h", c - 1, tr_rd[c], init_word(c - 2)); end
      end
    end
  endtask

  task automatic test_write_4word();
    for (int i = 0; i < 8; i++) wvals[i] = (i < 4) ? 32'(i + 1) : 32'hBAD0BAD0;
    do_req(32'h80020010, sz_4word, 1'b1);
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if ({tr_en[c], tr_pop[c], tr_rv[c], tr_done[c], tr_err[c]} !==
          {(c <= 4), (c <= 4), 1'b0, c == 5, 1'b0}) begin
        n_fail++; $display("FAIL w4_ctl cycle %0d got %b exp %b", c,
          {tr_en[c], tr_pop[c], tr_rv[c], tr_done[c], tr_err[c]},
          {(c <= 4), (c <= 4), 1'b0, c == 5, 1'b0});
      end
      if (c <= 4) begin
        n_checks++; if (tr_din[c] !== 32'(c) || tr_rw[c] !== 1'b0) begin n_fail++; $display("FAIL w4_din cycle %0d got %h/%b exp %h/0", c, tr_din[c], tr_rw[c], 32'(c)); end
      end
    end
    do_req(32'h80020010, sz_4word, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      n_checks++; if (tr_rd[c] !== 32'(c - 1) || tr_rv[c] !== 1'b1) begin n_fail++; $display("FAIL w4_readback beat %0d got %h exp %h", c - 1, tr_rd[c], 32'(c - 1)); end
    end
    n_checks++; if (tr_done[6] !== 1'b1 || tr_rl[5] !== 1'b1) begin n_fail++; $display("FAIL w4_rb_done got %b/%b exp 1/1", tr_done[6], tr_rl[5]); end
  endtask

  task automatic test_byte();
    do_req(32'h80020003, sz_byte, 1'b0);
    n_checks++; if (tr_rd[2] !== 32'h00000044 || tr_rv[2] !== 1'b1 || tr_rl[2] !== 1'b1) begin n_fail++; $display("FAIL byte_read got %h exp 00000044", tr_rd[2]); end
    n_checks++; if (tr_done[3] !== 1'b1) begin n_fail++; $display("FAIL byte_read_done got %b exp 1", tr_done[3]); end
    wvals[0] = 32'hFFFFFFAB;
    do_req(32'h80020001, sz_byte, 1'b1);
    n_checks++; if (tr_din[1] !== 32'h000000AB || tr_pop[1] !== 1'b1 || tr_pop[2] !== 1'b0) begin n_fail++; $display("FAIL byte_write_din got %h exp 000000ab", tr_din[1]); end
    n_checks++; if (tr_done[2] !== 1'b1 || tr_done[3] !== 1'b0) begin n_fail++; $display("FAIL byte_write_done got %b%b exp 10", tr_done[2], tr_done[3]); end
    do_req(32'h80020000, sz_word, 1'b0);
    n_checks++; if (tr_rd[2] !== 32'h11AB3344) begin n_fail++; $display("FAIL byte_readback got %h exp 11ab3344", tr_rd[2]); end
  endtask

  task automatic test_errors();
    do_req(32'h80020002, sz_word, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if ({tr_en[c], tr_done[c], tr_err[c], tr_rv[c]} !== {1'b0, c == 1, c == 1, 1'b0}) begin
        n_fail++; $display("FAIL align_err cycle %0d got %b exp %b", c,
          {tr_en[c], tr_done[c], tr_err[c], tr_rv[c]}, {1'b0, c == 1, c == 1, 1'b0});
      end
    end
`else
    n_checks++; if (tr_addr[1] !== 32'h80020000 || tr_en[1] !== 1'b1) begin n_fail++; $display("FAIL align_addr got %h exp 80020000", tr_addr[1]); end
    n_checks++; if (tr_rd[2] !== 32'h11AB3344) begin n_fail++; $display("FAIL align_data got %h exp 11ab3344", tr_rd[2]); end
    n_checks++; if (tr_done[3] !== 1'b1 || tr_err[1] !== 1'b0 || tr_err[3] !== 1'b0) begin n_fail++; $display("FAIL align_done got %b/%b exp 1/0", tr_done[3], tr_err[3]); end
`endif
    do_req(32'h8001FFFC, sz_word, 1'b0);
    for (int c = 1; c < 16; c++) begin
      n_checks++;
      if ({tr_en[c], tr_done[c], tr_err[c], tr_rv[c]} !== {1'b0, c == 1, c == 1, 1'b0}) begin
        n_fail++; $display("FAIL base_err cycle %0d got %b exp %b", c,
          {tr_en[c], tr_done[c], tr_err[c], tr_rv[c]}, {1'b0, c == 1, c == 1, 1'b0});
      end
    end
  endtask

  task automatic test_busy();
    @(posedge clk); #1;
    mem_busy = 1'b1; req_valid = 1'b1; req_addr = 32'h80020004; req_size = sz_word; req_wr = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", req_ready); end
    @(posedge clk); #2;
    n_checks++; if (mem_enable !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_no_accept got %b%b exp 00", mem_enable, done); end
    req_valid = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h80020000; req_size = sz_8word; req_wr = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++; if (mem_enable !== 1'b1 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_active got %b%b exp 11", mem_enable, rd_valid); end
    rst = 1'b1; #1;
    n_checks++; if ({mem_enable, rd_valid, done, wr_pop, req_ready} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_drop got %b exp 00000", {mem_enable, rd_valid, done, wr_pop, req_ready}); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || mem_enable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hold got %b%b exp 00", done, mem_enable); end
    rst = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got %b exp 1", req_ready); end
    do_req(32'h80020004, sz_word, 1'b0);
    n_checks++; if (tr_rd[2] !== 32'hDEADBEEF || tr_rv[2] !== 1'b1 || tr_done[3] !== 1'b1) begin n_fail++; $display("FAIL mid_after got %h/%b exp deadbeef/1", tr_rd[2], tr_done[3]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    for (int i = 0; i < 8; i++) wvals[i] = 32'd0;
    test_reset();
    test_read_8word();
    test_read_word();
    test_write_4word();
    test_byte();
    test_errors();
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
